// File: rtl/rca_seq_pkg.sv
// Shared encodings for the nibble-serial adder controller.
package rca_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rca_4bit.sv
// 4-bit ripple-carry adder used as the nibble datapath.
module rca_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[4];

endmodule

// File: rtl/rca_seq_add_ctrl.sv
// Nibble-serial WIDTH-bit adder built on one rca_4bit, LSB nibble first, with valid/ready on both sides.
// Define RCA_SEQ_OVF_EN to produce the signed overflow flag; otherwise ovf is tied low.
module rca_seq_add_ctrl
    import rca_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 carry;
    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     b_r;
    logic [NIBBLE_W-1:0]  a_nib;
    logic [NIBBLE_W-1:0]  b_nib;
    logic [NIBBLE_W-1:0]  s_nib;
    logic                 nib_cout;
    logic [WIDTH-1:0]     sum_next;
    logic                 last;
    int unsigned          sh;

    always_comb begin
        sh       = NIBBLE_W * int'(cnt);
        a_nib    = NIBBLE_W'(a_r >> sh);
        b_nib    = NIBBLE_W'(b_r >> sh);
        // Replace only the nibble currently being produced.
        sum_next = (sum & ~(WIDTH'({NIBBLE_W{1'b1}}) << sh)) | (WIDTH'(s_nib) << sh);
        last     = (cnt == CNT_W'(NIB - 1));
    end

    rca_4bit u_rca (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry),
        .s    (s_nib),
        .cout (nib_cout)
    );

`ifdef RCA_SEQ_OVF_EN
    logic ovf_r;
    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            carry     <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
`ifdef RCA_SEQ_OVF_EN
            ovf_r     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r      <= a;
                        b_r      <= b;
                        carry    <= cin;
                        cnt      <= '0;
                        state    <= ST_RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    sum   <= sum_next;
                    carry <= nib_cout;
                    if (last) begin
                        cout      <= nib_cout;
`ifdef RCA_SEQ_OVF_EN
                        ovf_r     <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                     (s_nib[NIBBLE_W-1] != a_r[WIDTH-1]);
`endif
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rca_seq_add_ctrl.sv
// Scoreboard bench for rca_seq_add_ctrl (WIDTH=16) using directed hand-computed vectors.
module tb_rca_seq_add_ctrl;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

`ifdef RCA_SEQ_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;

    int    total = 0;
    int    bad   = 0;
    exp_t  exp_q[$];
    longint accept_t = 0;

    rca_seq_add_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic exp_t mk(input logic [15:0] s, input logic c, input logic o);
        exp_t e;
        e.sum  = s;
        e.cout = c;
        e.ovf  = o & OVF_ON;
        return e;
    endfunction

    task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                        input exp_t e, input bit push);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            timeout("send_wait_ready");
            return;
        end
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        cin      = cv;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        accept_t = $time;
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || !in_ready) timeout("wait_done");
    endtask

    // Monitor: compares the queue head on every valid cycle, pops on handshake.
    bit prev_ov  = 1'b0;
    bit chk_rdy  = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
            chk_rdy = 1'b0;
        end else begin
            if (chk_rdy) begin
                check("in_ready_after_done", 32'(in_ready), 32'd1);
                chk_rdy = 1'b0;
            end
            if (out_valid) begin
                if (!prev_ov) check("latency", 32'($time - accept_t), 32'd45);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got sum 0x%0h want none at %0t", sum, $time);
                end else begin
                    check("sum",           32'(sum),      32'(exp_q[0].sum));
                    check("cout",          32'(cout),     32'(exp_q[0].cout));
                    check("ovf",           32'(ovf),      32'(exp_q[0].ovf));
                    check("in_ready_done", 32'(in_ready), 32'd0);
                    check("busy_done",     32'(busy),     32'd1);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        chk_rdy = 1'b1;
                    end
                end
            end
            prev_ov = out_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum",       32'(sum),       32'd0);
        check("rst_cout",      32'(cout),      32'd0);
        check("rst_ovf",       32'(ovf),       32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd1);

        send(16'h1234, 16'h4321, 1'b0, mk(16'h5555, 1'b0, 1'b0), 1'b1);
        send(16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1'b1, 1'b0), 1'b1);
        send(16'h0000, 16'h0000, 1'b1, mk(16'h0001, 1'b0, 1'b0), 1'b1);
        send(16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 1'b0, 1'b1), 1'b1);
        send(16'h8000, 16'h8000, 1'b0, mk(16'h0000, 1'b1, 1'b1), 1'b1);
        send(16'h8765, 16'h9ABC, 1'b1, mk(16'h2222, 1'b1, 1'b1), 1'b1);
        wait_done();

        // Backpressure with a stray in_valid while the adder is running.
        out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0, mk(16'h3333, 1'b0, 1'b0), 1'b1);
        @(negedge clk);
        in_valid = 1'b1;
        a        = 16'hAAAA;
        b        = 16'h5555;
        cin      = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) timeout("bp_wait_valid");
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
        wait_done();

        // Reset in the middle of RUN, with the counter at 2.
        send(16'h1234, 16'h1111, 1'b0, mk(16'h0000, 1'b0, 1'b0), 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum",       32'(sum),       32'd0);
        check("midrst_cout",      32'(cout),      32'd0);
        check("midrst_busy",      32'(busy),      32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        send(16'h00FF, 16'h0001, 1'b0, mk(16'h0100, 1'b0, 1'b0), 1'b1);
        wait_done();

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
